// File: rtl/reg_write_arbiter.sv
// Three-requester register-file write arbiter: one holding buffer per requester,
// round-robin grant into a registered write port, optional suppression of r0 writes.
module reg_write_arbiter #(
  parameter bit DROP_R0 = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       req_valid_i,
  output logic [2:0]       req_ready_o,
  input  logic [2:0][4:0]  req_addr_i,
  input  logic [2:0][31:0] req_data_i,
  output logic             RegWrite_o,
  output logic [4:0]       RDaddr_o,
  output logic [31:0]      RDdata_o,
  output logic [31:0]      pend_mask_o,
  output logic [1:0]       grant_o
);

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;
  localparam logic [1:0] GRANT_IDLE = 2'd3;
  localparam logic [1:0] LAST_RESET = 2'd2;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_entry_t;

  wr_entry_t [NREQ-1:0] buf_q, buf_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic                 regwrite_q, regwrite_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;
  logic [1:0]           grant_q, grant_d;

  logic [NREQ-1:0]      buf_valid_c;
  logic [NREQ-1:0]      gnt_oh_c;
  logic [1:0]           gnt_idx_c;
  logic                 gnt_any_c;
  logic [AW-1:0]        gnt_addr_c;
  logic [DW-1:0]        gnt_data_c;
  logic                 gnt_drop_c;
  logic [NREG-1:0]      pend_mask_c;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      buf_valid_c[i] = buf_q[i].valid;
    end
  end

  // Round-robin: first occupied buffer after last_grant, wrapping; depends on registers only.
  always_comb begin
    gnt_idx_c = GRANT_IDLE;
    case (last_grant_q)
      2'd0: begin
        if      (buf_valid_c[1]) gnt_idx_c = 2'd1;
        else if (buf_valid_c[2]) gnt_idx_c = 2'd2;
        else if (buf_valid_c[0]) gnt_idx_c = 2'd0;
      end
      2'd1: begin
        if      (buf_valid_c[2]) gnt_idx_c = 2'd2;
        else if (buf_valid_c[0]) gnt_idx_c = 2'd0;
        else if (buf_valid_c[1]) gnt_idx_c = 2'd1;
      end
      default: begin
        if      (buf_valid_c[0]) gnt_idx_c = 2'd0;
        else if (buf_valid_c[1]) gnt_idx_c = 2'd1;
        else if (buf_valid_c[2]) gnt_idx_c = 2'd2;
      end
    endcase
    gnt_any_c = (gnt_idx_c != GRANT_IDLE);
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt_oh_c[i] = (gnt_idx_c == 2'(i));
    end
  end

  always_comb begin
    gnt_addr_c = '0;
    gnt_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_oh_c[i]) begin
        gnt_addr_c = buf_q[i].addr;
        gnt_data_c = buf_q[i].data;
      end
    end
    gnt_drop_c = DROP_R0 && (gnt_addr_c == '0);
  end

  // A granted buffer frees its slot in the same cycle, allowing a refill at the edge.
  assign req_ready_o = ~buf_valid_c | gnt_oh_c;

  always_comb begin
    buf_d = buf_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_oh_c[i]) begin
        buf_d[i].valid = 1'b0;
      end
      if (req_valid_i[i] && req_ready_o[i]) begin
        buf_d[i].valid = 1'b1;
        buf_d[i].addr  = req_addr_i[i];
        buf_d[i].data  = req_data_i[i];
      end
    end
  end

  // Dropped r0 writes still consume the slot and advance the round-robin pointer.
  always_comb begin
    regwrite_d   = 1'b0;
    grant_d      = GRANT_IDLE;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    last_grant_d = last_grant_q;
    if (gnt_any_c) begin
      last_grant_d = gnt_idx_c;
      if (!gnt_drop_c) begin
        regwrite_d = 1'b1;
        grant_d    = gnt_idx_c;
        rd_addr_d  = gnt_addr_c;
        rd_data_d  = gnt_data_c;
      end
    end
  end

  always_comb begin
    pend_mask_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (buf_q[i].valid) begin
        pend_mask_c = pend_mask_c | (NREG'(1) << buf_q[i].addr);
      end
    end
    if (regwrite_q) begin
      pend_mask_c = pend_mask_c | (NREG'(1) << rd_addr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_q        <= '0;
      last_grant_q <= LAST_RESET;
      regwrite_q   <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      grant_q      <= GRANT_IDLE;
    end else begin
      buf_q        <= buf_d;
      last_grant_q <= last_grant_d;
      regwrite_q   <= regwrite_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      grant_q      <= grant_d;
    end
  end

  assign RegWrite_o  = regwrite_q;
  assign RDaddr_o    = rd_addr_q;
  assign RDdata_o    = rd_data_q;
  assign grant_o     = grant_q;
  assign pend_mask_o = pend_mask_c;

endmodule
